// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: single outstanding access, alignment check, timeout
module lsu #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       op;
    logic [OFF_W-1:0] offset;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       req_bytes;
    logic             misaligned;
    logic             timed_out;
    logic [DATA_W-1:0] load_shifted;

    // Low-order mask covering 8<<sz bits; a size wider than the bus yields all ones.
    function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] sz);
        return ~({DATA_W{1'b1}} << (7'd8 << sz));
    endfunction

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] sz,
                                                 input logic zext);
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] top;
        logic              neg;
        m   = size_mask(sz);
        top = m ^ (m >> 1);
        neg = (|(d & top)) && !zext;
        return (d & m) | (neg ? ~m : {DATA_W{1'b0}});
    endfunction

    assign req_ready  = (state == IDLE);
    assign mem_valid  = (state == ISSUE);
    assign resp_valid = (state == RESP);

    assign req_bytes    = 4'd1 << req_op[1:0];
    assign misaligned   = (({1'b0, req_addr[2:0]} & (req_bytes - 4'd1)) != 4'd0) ||
                          (req_bytes > 4'(NB));
    assign timed_out    = (cnt == CNT_W'(TIMEOUT));
    assign load_shifted = mem_rdata >> {offset, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = misaligned ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op         <= 4'd0;
            offset     <= '0;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op         <= req_op;
                        offset     <= req_addr[OFF_W-1:0];
                        resp_rdata <= '0;
                        resp_err   <= misaligned;
                        if (!misaligned) begin
                            mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_we   <= req_op[3];
                            if (req_op[3]) begin
                                mem_wdata <= (req_wdata & size_mask(req_op[1:0]))
                                             << {req_addr[OFF_W-1:0], 3'b000};
                                mem_wmask <= (~({NB{1'b1}} << req_bytes))
                                             << req_addr[OFF_W-1:0];
                            end else begin
                                mem_wdata <= '0;
                                mem_wmask <= '0;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        cnt <= '0;
                    end
                end
                WAIT: begin
                    // A completion in the timeout cycle still counts as success.
                    if (mem_rvalid) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= op[3] ? '0 : extend(load_shifted, op[1:0], op[2]);
                    end else if (timed_out) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed vector bench for lsu
module tb_lsu;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int tests  = 0;
    int errors = 0;

    lsu #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        mis;
        logic [63:0] maddr;
        logic        we;
        logic [7:0]  wmask;
        logic [63:0] mwdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        check({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.mis) begin
            check({tag, " mis mem_valid"}, 64'(mem_valid), 64'd0);
            check({tag, " mis resp_valid"}, 64'(resp_valid), 64'd1);
        end else begin
            check({tag, " mem_valid"}, 64'(mem_valid), 64'd1);
            check({tag, " mem_addr"}, mem_addr, v.maddr);
            check({tag, " mem_we"}, 64'(mem_we), 64'(v.we));
            check({tag, " mem_wmask"}, 64'(mem_wmask), 64'(v.wmask));
            check({tag, " mem_wdata"}, mem_wdata, v.mwdata);
            mem_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_ready  = 1'b0;
            check({tag, " wait resp_valid"}, 64'(resp_valid), 64'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            @(posedge clk);
            @(negedge clk);
            mem_rvalid = 1'b0;
            check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        end
        check({tag, " resp_rdata"}, resp_rdata, v.exp_rdata);
        check({tag, " resp_err"}, 64'(resp_err), 64'(v.exp_err));
        check({tag, " req_ready resp"}, 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, " back idle"}, 64'(resp_valid), 64'd0);
    endtask

    task automatic issue_handshake(input logic [3:0] op, input logic [63:0] addr);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = 64'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic early;
        logic [63:0] held_rdata;
        logic        held_err;

        vecs[0]  = '{4'b0000, 64'h80000003, 64'h0, 64'h0000000080000000, 1'b0,
                     64'h80000000, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0};
        vecs[1]  = '{4'b1001, 64'h80000006, 64'h1234, 64'h0, 1'b0,
                     64'h80000000, 1'b1, 8'hC0, 64'h1234000000000000, 64'h0, 1'b0};
        vecs[2]  = '{4'b0010, 64'h80000002, 64'h0, 64'h0, 1'b1,
                     64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1};
        vecs[3]  = '{4'b0011, 64'h1000, 64'h0, 64'h0123456789ABCDEF, 1'b0,
                     64'h1000, 1'b0, 8'h00, 64'h0, 64'h0123456789ABCDEF, 1'b0};
        vecs[4]  = '{4'b0101, 64'h1002, 64'h0, 64'h0123456789ABCDEF, 1'b0,
                     64'h1000, 1'b0, 8'h00, 64'h0, 64'h00000000000089AB, 1'b0};
        vecs[5]  = '{4'b0001, 64'h1002, 64'h0, 64'h0123456789ABCDEF, 1'b0,
                     64'h1000, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFFFFFF89AB, 1'b0};
        vecs[6]  = '{4'b1010, 64'h2004, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0,
                     64'h2000, 1'b1, 8'hF0, 64'hCAFEF00D00000000, 64'h0, 1'b0};
        vecs[7]  = '{4'b1011, 64'h2000, 64'h1122334455667788, 64'h0, 1'b0,
                     64'h2000, 1'b1, 8'hFF, 64'h1122334455667788, 64'h0, 1'b0};
        vecs[8]  = '{4'b1000, 64'h2005, 64'h00000000000000AB, 64'h0, 1'b0,
                     64'h2000, 1'b1, 8'h20, 64'h0000AB0000000000, 64'h0, 1'b0};
        vecs[9]  = '{4'b1011, 64'h2004, 64'h1, 64'h0, 1'b1,
                     64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1};
        vecs[10] = '{4'b0010, 64'h3004, 64'h0, 64'h8000000100000000, 1'b0,
                     64'h3000, 1'b0, 8'h00, 64'h0, 64'hFFFFFFFF80000001, 1'b0};
        vecs[11] = '{4'b0000, 64'h3000, 64'h0, 64'hFFFFFFFFFFFFFF7F, 1'b0,
                     64'h3000, 1'b0, 8'h00, 64'h0, 64'h000000000000007F, 1'b0};
        vecs[12] = '{4'b0001, 64'h3001, 64'h0, 64'h0, 1'b1,
                     64'h0, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 4'd0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'd0;
        #3;
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset mem_valid", 64'(mem_valid), 64'd0);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset mem_addr", mem_addr, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // ISSUE stall: fields held, stray rvalid ignored
        req_valid = 1'b1; req_op = 4'b1010; req_addr = 64'h4008; req_wdata = 64'h55AA55AA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            mem_rvalid = 1'b0;
            check("stall mem_valid", 64'(mem_valid), 64'd1);
            check("stall mem_wdata", mem_wdata, 64'h0000000055AA55AA);
            check("stall mem_wmask", 64'(mem_wmask), 64'h0F);
        end
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("stall store resp_rdata", resp_rdata, 64'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;

        // Timeout with rvalid held low
        mem_rdata = 64'hF000000000000000;
        issue_handshake(4'b0110, 64'h80000004);
        n = 0;
        while (!resp_valid && n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("timeout cycles", 64'(n), 64'(TIMEOUT + 1));
        check("timeout resp_err", 64'(resp_err), 64'd1);
        check("timeout resp_rdata", resp_rdata, 64'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;

        // rvalid in the cycle the counter equals TIMEOUT
        issue_handshake(4'b0110, 64'h80000004);
        early = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (resp_valid) early = 1'b1;
        end
        check("no early resp", 64'(early), 64'd0);
        mem_rvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late rvalid resp_valid", 64'(resp_valid), 64'd1);
        check("late rvalid resp_err", 64'(resp_err), 64'd0);
        check("late rvalid resp_rdata", resp_rdata, 64'h00000000F0000000);

        // Backpressure on the response
        held_rdata = resp_rdata;
        held_err   = resp_err;
        req_valid  = 1'b1;
        req_op     = 4'b0000;
        req_addr   = 64'h5000;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold resp_valid", 64'(resp_valid), 64'd1);
            check("hold resp_rdata", resp_rdata, held_rdata);
            check("hold resp_err", 64'(resp_err), 64'(held_err));
            check("hold req_ready", 64'(req_ready), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("after hold idle", 64'(req_ready), 64'd1);

        // Asynchronous reset while in WAIT
        issue_handshake(4'b1011, 64'h6000);
        check("pre-reset mem_we", 64'(mem_we), 64'd1);
        rst = 1'b1;
        #1;
        check("async rst req_ready", 64'(req_ready), 64'd1);
        check("async rst mem_we", 64'(mem_we), 64'd0);
        check("async rst mem_wmask", 64'(mem_wmask), 64'd0);
        check("async rst mem_wdata", mem_wdata, 64'd0);
        check("async rst mem_addr", mem_addr, 64'd0);
        check("async rst resp_err", 64'(resp_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1234;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("post-rst no resp", 64'(resp_valid), 64'd0);
            check("post-rst no mem_valid", 64'(mem_valid), 64'd0);
            check("post-rst rdata", resp_rdata, 64'd0);
            @(posedge clk);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_W, default 64, address width.
REQ-002 Parameter DATA_W, default 64, data and bus width; legal values are 32 and 64.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before an error response.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1 / req_ready  out  1  request handshake.
REQ-007 req_op  in  4  operation: bit3=store; bit2=zero-extend (loads only); bits1:0 size (0=1B, 1=2B, 2=4B, 3=8B).
REQ-008 req_addr  in  ADDR_W / req_wdata  in  DATA_W  byte address and store data (data is right-aligned).
REQ-009 resp_valid  out  1 / resp_ready  in  1  response handshake.
REQ-010 resp_rdata  out  DATA_W / resp_err  out  1  load result and error flag.
REQ-011 mem_valid  out  1 / mem_ready  in  1  memory request handshake.
REQ-012 mem_we  out  1, mem_addr  out  ADDR_W, mem_wdata  out  DATA_W, mem_wmask  out  DATA_W/8  memory request fields.
REQ-013 mem_rvalid  in  1 / mem_rdata  in  DATA_W  completion for loads and stores (no ready; always accepted).

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 Accept on req_valid&&req_ready; op, addr and wdata are latched.
REQ-017 Misaligned = addr not a multiple of size, or size > DATA_W/8.
- Misaligned accept: IDLE->RESP, resp_err=1, resp_rdata=0, no memory request.
- Otherwise: IDLE->ISSUE.
REQ-018 In ISSUE: mem_valid=1, fields stable until mem_ready.
- mem_addr = addr with low log2(DATA_W/8) bits cleared.
- Store: mem_wdata = wdata shifted left by offset*8; mem_wmask = size-wide strobe shifted by offset.
- Load: mem_wmask=0, mem_we=0.
REQ-019 mem_valid&&mem_ready SHALL move ISSUE->WAIT and clear the timeout counter.
REQ-020 mem_rvalid is ignored outside WAIT; memory SHALL NOT assert it in the handshake cycle.
REQ-021 In WAIT, mem_rvalid moves to RESP with resp_err=0.
- Load: resp_rdata = mem_rdata shifted right by offset*8, truncated to size, sign-extended (bit2=0) or zero-extended (bit2=1).
- Store: resp_rdata = 0.
REQ-022 In WAIT the counter increments each cycle without mem_rvalid; reaching TIMEOUT moves to RESP, resp_err=1, resp_rdata=0.
REQ-023 If mem_rvalid arrives in the same cycle as counter==TIMEOUT, mem_rvalid wins (no error).
REQ-024 In RESP, resp_valid=1 with data stable until resp_ready, then IDLE.
- A new request is accepted no earlier than the following cycle.
REQ-025 Latency, aligned access with mem_ready=1 and rvalid one cycle after the handshake: accept at cycle 0, mem_valid at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.
REQ-026 Misaligned access: resp_valid one cycle after accept.
REQ-027 All outputs SHALL be registered or decoded from the state register only; there are no combinational paths from inputs to outputs.

Reset
REQ-028 rst=1 SHALL force IDLE asynchronously from any state, including ISSUE and WAIT.
- Counter=0; mem_valid=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- req_ready=1 while rst=1 and after release.
REQ-029 A mem_rvalid arriving after reset is ignored.

Verification
REQ-030 LB signed, addr 0x80000003, mem_rdata 0x0000000080000000 -> mem_addr 0x80000000, resp_rdata 0xFFFFFFFFFFFFFF80, resp_err 0.
REQ-031 SH, addr 0x80000006, wdata 0x1234 -> mem_addr 0x80000000, mem_wmask 0xC0, mem_wdata 0x1234000000000000, mem_we 1.
REQ-032 LW, addr 0x80000002 -> no mem_valid, resp_valid one cycle after accept, resp_err 1, resp_rdata 0.
REQ-033 LWU, addr 0x80000004, mem_rdata 0xF0000000_00000000 with mem_rvalid held low -> after TIMEOUT WAIT cycles resp_err 1; repeated with rvalid at count TIMEOUT -> resp_rdata 0x00000000F0000000, resp_err 0.
REQ-034 Hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stable, req_ready 0; then rst=1 in WAIT -> IDLE immediately, all outputs at reset values, late mem_rvalid produces no response.
